inst_fetch_queue: RTL and testbench

//   Instruction fetch queue between the fetch stage / instruction ROM and the decode stage.

---
 rtl/inst_fetch_queue.sv | 78 +++++++
 tb/tb_inst_fetch_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a small circular buffer of {pc, inst} pairs between fetch and decode.
// Flush empties the queue, hold freezes it, and the decode side reads the head without a bypass.
module inst_fetch_queue #(
   parameter int          DEPTH = 4,
   parameter int          PTR_W = 2,
   parameter logic [31:0] NOP   = 32'h13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_inst,
   output logic             in_allow,
   input  logic             flush,
   input  logic             hold,
   output logic             out_valid,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_inst,
   input  logic             out_ready,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [31:0]      pc_mem_q   [DEPTH];
   logic [31:0]      inst_mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push, pop;

   // in_allow looks only at local state and hold, so decode never reaches back into fetch.
   assign in_allow  = (count_q != FULL) & ~hold;
   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
   assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : NOP;
   assign count     = count_q;

   assign push = in_valid  & in_allow  & ~hold & ~flush;
   assign pop  = out_valid & out_ready & ~hold & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; count gates what is ever presented.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= in_pc;
         inst_mem_q[wr_ptr_q] <= in_inst;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: fill/drain, streaming across the wrap, flush, hold, async reset.
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_allow;
   logic        flush;
   logic        hold;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   inst_fetch_queue #(.DEPTH(4), .PTR_W(2), .NOP(32'h13)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_allow  (in_allow),
      .flush     (flush),
      .hold      (hold),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .out_ready (out_ready),
      .count     (count)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
      in_valid = 1'b1;
      in_pc    = pc;
      in_inst  = inst;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
      flush = 1'b0; hold = 1'b0; out_ready = 1'b0;
      #2;
      check_eq("rst_out_valid", 32'(out_valid), 32'h0);
      check_eq("rst_count",     32'(count),     32'h0);
      check_eq("rst_out_pc",    out_pc,         32'h0);
      check_eq("rst_out_inst",  out_inst,       32'h13);
      step(); step();
      rst_n = 1'b1;
      step();
      check_eq("rst_in_allow",  32'(in_allow),  32'h1);

      // 1: two pushes, decode stalled
      push_one(32'h0, 32'h00500093);
      push_one(32'h4, 32'h00100113);
      check_eq("t1_count",    32'(count),    32'h2);
      check_eq("t1_out_pc",   out_pc,        32'h0);
      check_eq("t1_out_inst", out_inst,      32'h00500093);
      check_eq("t1_in_allow", 32'(in_allow), 32'h1);
      flush = 1'b1; step(); flush = 1'b0;
      check_eq("t1_flush_count", 32'(count), 32'h0);

      // 2: fill to full, drop a fifth push, then drain in order
      for (int i = 0; i < 4; i++) push_one(32'(i*4), 32'h1000 + 32'(i));
      check_eq("t2_count_full", 32'(count),    32'h4);
      check_eq("t2_in_allow",   32'(in_allow), 32'h0);
      push_one(32'h10, 32'h1004);
      check_eq("t2_drop_count", 32'(count),    32'h4);
      check_eq("t2_drop_head",  out_pc,        32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("t2_drain_valid", 32'(out_valid), 32'h1);
         check_eq("t2_drain_pc",    out_pc,         32'(i*4));
         check_eq("t2_drain_inst",  out_inst,       32'h1000 + 32'(i));
         step();
      end
      check_eq("t2_empty_valid", 32'(out_valid), 32'h0);
      check_eq("t2_empty_inst",  out_inst,       32'h13);
      check_eq("t2_empty_count", 32'(count),     32'h0);

      // 3: steady stream across the pointer wrap
      for (int i = 0; i < 10; i++) begin
         if (out_valid) begin
            if (exp_q.size() == 0) check_eq("t3_unexpected_pop", out_pc, 32'hffffffff);
            else                   check_eq("t3_stream_pc", out_pc, exp_q.pop_front());
         end
         in_valid = 1'b1;
         in_pc    = 32'(i*4);
         in_inst  = 32'h2000 + 32'(i);
         exp_q.push_back(32'(i*4));
         step();
         check_eq("t3_count", 32'(count), 32'h1);
      end
      in_valid = 1'b0;
      check_eq("t3_last_valid", 32'(out_valid), 32'h1);
      if (exp_q.size() == 0) check_eq("t3_unexpected_pop", out_pc, 32'hffffffff);
      else                   check_eq("t3_last_pc", out_pc, exp_q.pop_front());
      check_eq("t3_last_inst", out_inst, 32'h2009);
      step();
      check_eq("t3_end_count", 32'(count), 32'h0);
      check_eq("t3_queue_left", 32'(exp_q.size()), 32'h0);
      out_ready = 1'b0;

      // 4: flush wins over a simultaneous push
      push_one(32'h0, 32'h3000);
      push_one(32'h4, 32'h3001);
      push_one(32'h8, 32'h3002);
      check_eq("t4_count3", 32'(count), 32'h3);
      in_valid = 1'b1; in_pc = 32'hC; in_inst = 32'h3003; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      check_eq("t4_flush_count", 32'(count),     32'h0);
      check_eq("t4_flush_valid", 32'(out_valid), 32'h0);
      push_one(32'h40, 32'h3010);
      check_eq("t4_new_pc",    out_pc,     32'h40);
      check_eq("t4_new_count", 32'(count), 32'h1);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      check_eq("t4_drained", 32'(count), 32'h0);

      // 5: hold freezes both sides
      push_one(32'h80, 32'h4000);
      push_one(32'h84, 32'h4001);
      hold = 1'b1; in_valid = 1'b1; in_pc = 32'h88; in_inst = 32'h4002; out_ready = 1'b1;
      #1;
      check_eq("t5_hold_allow_now", 32'(in_allow), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("t5_hold_count", 32'(count),    32'h2);
         check_eq("t5_hold_pc",    out_pc,        32'h80);
         check_eq("t5_hold_allow", 32'(in_allow), 32'h0);
      end
      hold = 1'b0; in_valid = 1'b0;
      check_eq("t5_resume_pc0", out_pc, 32'h80);
      step();
      check_eq("t5_resume_pc1", out_pc, 32'h84);
      step();
      check_eq("t5_resume_empty", 32'(out_valid), 32'h0);
      out_ready = 1'b0;

      // 6: asynchronous reset between edges
      push_one(32'hA0, 32'h5000);
      push_one(32'hA4, 32'h5001);
      check_eq("t6_pre_count", 32'(count), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_valid", 32'(out_valid), 32'h0);
      check_eq("t6_async_count", 32'(count),     32'h0);
      #10;
      rst_n = 1'b1;
      #1;
      check_eq("t6_rel_allow", 32'(in_allow), 32'h1);
      check_eq("t6_rel_inst",  out_inst,      32'h13);
      step();
      check_eq("t6_rel_valid", 32'(out_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
